// File: rtl/serial_mult_stream_if.sv
// Handshake bundle for serial_mult_stream: operand input channel, serial product output
// channel and a busy flag.
interface serial_mult_stream_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_bit, out_last, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_bit, out_last, busy
  );
endinterface

// File: rtl/serial_mult_stream.sv
// Serial shift-add multiplier: accepts one operand pair, then streams the 2*WIDTH-bit
// product LSB-first under out_valid/out_ready flow control. Unsigned or two's-complement.
module serial_mult_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(2 * WIDTH)
) (
  input logic                  clock,
  input logic                  reset,
  serial_mult_stream_if.slave  s_io
);

  localparam logic [CNT_W-1:0] LastK = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] MsbK  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] WidK  = CNT_W'(WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH:0]   acc_q, acc_d;

  // Two guard bits above the accumulator keep the sum exact, including -A for A = -2^(W-1).
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] acc_ext;
  logic [WIDTH+1:0] partial;
  logic [WIDTH+1:0] sum;
  logic             run;

  always_comb begin
    run     = (state_q == StRun);
    a_ext   = {{2{signed_q & a_q[WIDTH-1]}}, a_q};
    acc_ext = {signed_q & acc_q[WIDTH], acc_q};
    partial = '0;
    // b_q is shifted right on each transfer, so b_q[0] is multiplier bit k.
    if ((k_q < WidK) && b_q[0]) begin
      partial = (signed_q && (k_q == MsbK)) ? -a_ext : a_ext;
    end
    sum = acc_ext + partial;
  end

  always_comb begin
    s_io.in_ready  = (state_q == StIdle);
    s_io.out_valid = run;
    s_io.busy      = run;
    s_io.out_bit   = run & sum[0];
    s_io.out_last  = run & (k_q == LastK);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    k_d      = k_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (s_io.in_valid) begin
          a_d      = s_io.in_a;
          b_d      = s_io.in_b;
          signed_d = s_io.in_signed;
          k_d      = '0;
          acc_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (s_io.out_ready) begin
          // Dropping sum[0] is the shift; the guard bit makes it arithmetic when signed.
          acc_d = sum[WIDTH+1:1];
          b_d   = b_q >> 1;
          k_d   = k_q + CNT_W'(1);
          if (k_q == LastK) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_serial_mult_stream.sv
// Directed bench for serial_mult_stream: WIDTH=16 vectors with backpressure, reset and
// operand-hold cases, plus an exhaustive WIDTH=4 sweep against an arithmetic model.
module tb_serial_mult_stream;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;
  int   cyc_cnt;

  serial_mult_stream_if #(.WIDTH(16)) i16 ();
  serial_mult_stream_if #(.WIDTH(4))  i4 ();

  serial_mult_stream #(.WIDTH(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .s_io  (i16)
  );

  serial_mult_stream #(.WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .s_io  (i4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one WIDTH=16 operation starting at a negedge with in_ready=1.
  // viol counts protocol breaches: in_ready/out_valid/busy wrong in RUN, early out_last,
  // or out_bit/out_last changing while stalled.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input int pct, input bit hold,
                      output logic [31:0] prod, output int ncyc, output int last_at,
                      output int viol);
    int   bits;
    logic pb;
    logic pl;
    bit   stalled;
    prod    = '0;
    bits    = 0;
    ncyc    = 0;
    last_at = -1;
    viol    = 0;
    stalled = 1'b0;
    pb      = 1'b0;
    pl      = 1'b0;
    i16.in_a      = a;
    i16.in_b      = b;
    i16.in_signed = s;
    i16.in_valid  = 1'b1;
    @(negedge clock);
    if (!hold) i16.in_valid = 1'b0;
    while (bits < 32 && ncyc < 500) begin
      if (hold) begin
        i16.in_a      = 16'($urandom);
        i16.in_b      = 16'($urandom);
        i16.in_signed = ~i16.in_signed;
      end
      if (i16.in_ready !== 1'b0 || i16.out_valid !== 1'b1 || i16.busy !== 1'b1) viol++;
      if (stalled && (i16.out_bit !== pb || i16.out_last !== pl)) viol++;
      i16.out_ready = ($urandom_range(99) < pct);
      if (i16.out_ready) begin
        prod[bits] = i16.out_bit;
        if (i16.out_last === 1'b1) begin
          if (bits != 31) viol++;
          last_at = bits;
        end
        bits++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pb      = i16.out_bit;
        pl      = i16.out_last;
      end
      ncyc++;
      @(negedge clock);
    end
    i16.in_valid  = 1'b0;
    i16.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] prod;
    int          ncyc;
    int          last_at;
    int          viol;
    int          bad;
    int          t0;
    logic [7:0]  got;
    logic [7:0]  exp4;

    n_pass  = 0;
    n_total = 0;
    cyc_cnt = 0;
    reset   = 1'b1;
    i16.in_valid = 1'b0; i16.in_a = '0; i16.in_b = '0; i16.in_signed = 1'b0; i16.out_ready = 1'b0;
    i4.in_valid  = 1'b0; i4.in_a  = '0; i4.in_b  = '0; i4.in_signed  = 1'b0; i4.out_ready  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset16 rdy/vld/bit/last/busy",
          {i16.in_ready, i16.out_valid, i16.out_bit, i16.out_last, i16.busy}, 5'b10000);
    check("reset4 rdy/vld/bit/last/busy",
          {i4.in_ready, i4.out_valid, i4.out_bit, i4.out_last, i4.busy}, 5'b10000);
    reset = 1'b0;
    @(negedge clock);

    // 3 * 5 unsigned at full rate
    op16(16'd3, 16'd5, 1'b0, 100, 1'b0, prod, ncyc, last_at, viol);
    check("u 3*5 product", prod, 32'h0000000F);
    check("u 3*5 cycles", ncyc, 32);
    check("u 3*5 last idx", last_at, 31);
    check("u 3*5 protocol", viol, 0);
    check("u 3*5 idle after", {i16.in_ready, i16.out_valid, i16.busy}, 3'b100);

    op16(16'hFFFF, 16'hFFFF, 1'b0, 100, 1'b0, prod, ncyc, last_at, viol);
    check("u ffff*ffff", prod, 32'hFFFE0001);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 100, 1'b0, prod, ncyc, last_at, viol);
    check("s -1*-1", prod, 32'h00000001);
    check("s -1*-1 protocol", viol, 0);
    op16(16'h8000, 16'h0001, 1'b1, 100, 1'b0, prod, ncyc, last_at, viol);
    check("s 8000*0001", prod, 32'hFFFF8000);
    op16(16'h0001, 16'h8000, 1'b1, 100, 1'b0, prod, ncyc, last_at, viol);
    check("s 0001*8000", prod, 32'hFFFF8000);
    op16(16'h8000, 16'h8000, 1'b1, 100, 1'b0, prod, ncyc, last_at, viol);
    check("s 8000*8000", prod, 32'h40000000);

    // Random 50% backpressure
    op16(16'h1234, 16'h5678, 1'b0, 50, 1'b0, prod, ncyc, last_at, viol);
    check("bp 1234*5678", prod, 32'h06260060);
    check("bp last idx", last_at, 31);
    check("bp stall stable", viol, 0);

    // Reset in the middle of a product, at bit 10
    i16.in_a = 16'h1234; i16.in_b = 16'h5678; i16.in_signed = 1'b0; i16.in_valid = 1'b1;
    @(negedge clock);
    i16.in_valid  = 1'b0;
    i16.out_ready = 1'b1;
    repeat (10) @(negedge clock);
    check("pre-reset busy", {i16.out_valid, i16.busy}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    check("mid reset state",
          {i16.in_ready, i16.out_valid, i16.out_bit, i16.out_last, i16.busy}, 5'b10000);
    reset = 1'b0;
    i16.out_ready = 1'b0;
    op16(16'd2, 16'd2, 1'b0, 100, 1'b0, prod, ncyc, last_at, viol);
    check("post-reset 2*2", prod, 32'h00000004);
    check("post-reset cycles", ncyc, 32);

    // in_valid held high with operands changing during RUN
    op16(16'hBEEF, 16'h0123, 1'b0, 100, 1'b1, prod, ncyc, last_at, viol);
    check("hold beef*0123", prod, 32'h00D909AD);
    check("hold in_ready low in RUN", viol, 0);
    @(negedge clock);
    check("hold no extra accept", {i16.in_ready, i16.out_valid}, 2'b10);

    // WIDTH=4 exhaustive, back-to-back at full rate
    bad = 0;
    i4.out_ready = 1'b1;
    t0 = cyc_cnt;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int sa;
          int sb;
          if (i4.in_ready !== 1'b1) bad++;
          i4.in_a      = 4'(a);
          i4.in_b      = 4'(b);
          i4.in_signed = (s != 0);
          i4.in_valid  = 1'b1;
          @(negedge clock);
          i4.in_valid = 1'b0;
          got = '0;
          for (int j = 0; j < 8; j++) begin
            if (i4.out_valid !== 1'b1 || i4.in_ready !== 1'b0) bad++;
            if (i4.out_last !== (j == 7)) bad++;
            got[j] = i4.out_bit;
            @(negedge clock);
          end
          sa   = (s != 0 && a > 7) ? a - 16 : a;
          sb   = (s != 0 && b > 7) ? b - 16 : b;
          exp4 = 8'((sa * sb) & 255);
          check($sformatf("w4 s=%0d %0d*%0d", s, a, b), got, exp4);
        end
      end
    end
    check("w4 framing/latency", bad, 0);
    check("w4 period 9 cycles", cyc_cnt - t0, 512 * 9);
    check("w4 idle at end", {i4.in_ready, i4.out_valid, i4.busy}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
